// File: rtl/trsq_bus_pkg.sv
// Shared definitions for the 8-bit peripheral bus: widths, arbiter states and
// the DMA beat record.
package trsq_bus_pkg;

    localparam int PERI_ADDR_W = 8;
    localparam int PERI_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                   we;
        logic [PERI_ADDR_W-1:0] addr;
        logic [PERI_DATA_W-1:0] wdata;
    } beat_t;

endpackage

// File: rtl/starve_cnt.sv
// Saturating event counter with synchronous clear and a limit flag; also used
// for interrupt latency monitoring.
module starve_cnt #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic at_limit
);

    localparam logic [W-1:0] LIM = LIMIT[W-1:0];

    logic [W-1:0] count;

    // Clear wins over enable so a new wait period always starts from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LIM)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == LIM);

endmodule

// File: rtl/peri_bus_arb.sv
// Cycle-stealing arbiter: the CPU owns the peripheral bus whenever it strobes,
// and a single queued DMA beat is slipped into the first CPU-idle cycle.
module peri_bus_arb
    import trsq_bus_pkg::*;
#(
    parameter int ADDR_W       = PERI_ADDR_W,
    parameter int DATA_W       = PERI_DATA_W,
    parameter int STARVE_LIMIT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_dout,
    input  logic              cpu_wr_en,
    input  logic              cpu_rd_en,
    output logic [DATA_W-1:0] cpu_din,
    output logic [ADDR_W-1:0] peri_addr,
    output logic [DATA_W-1:0] peri_dout,
    output logic              peri_wr_en,
    output logic              peri_rd_en,
    input  logic [DATA_W-1:0] peri_din,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ready,
    output logic              dma_done,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_starved,
    output logic [1:0]        dbg_state
);

    // DMA handshake: a beat transfers on any rising edge where dma_req and
    // dma_ready are both high; dma_req seen while dma_ready is low is ignored.

    arb_state_t state, state_nxt;

    logic              beat_we;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] beat_wdata;

    logic cpu_busy;
    logic issue;
    logic accept;
    logic starve_at_limit;

    assign cpu_busy = cpu_wr_en | cpu_rd_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dma_ready = 1'b0;
        dma_done  = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                dma_ready = 1'b1;
                if (dma_req) state_nxt = PEND;
            end
            PEND: begin
                issue = ~cpu_busy;
                if (issue) state_nxt = DONE;
            end
            DONE: begin
                dma_ready = 1'b1;
                dma_done  = 1'b1;
                state_nxt = dma_req ? PEND : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = dma_ready & dma_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_we    <= 1'b0;
            beat_addr  <= '0;
            beat_wdata <= '0;
        end else if (accept) begin
            beat_we    <= dma_we;
            beat_addr  <= dma_addr;
            beat_wdata <= dma_wdata;
        end
    end

    // Read data is captured in the issue cycle and held across later writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dma_rdata <= '0;
        end else if (issue && !beat_we) begin
            dma_rdata <= peri_din;
        end
    end

    assign peri_addr  = issue ? beat_addr  : cpu_addr;
    assign peri_dout  = issue ? beat_wdata : cpu_dout;
    assign peri_wr_en = issue ? beat_we    : cpu_wr_en;
    assign peri_rd_en = issue ? ~beat_we   : cpu_rd_en;

    assign cpu_din = cpu_rd_en ? peri_din : '0;

    // Every accept enters PEND, so accept doubles as the counter clear.
    starve_cnt #(
        .W     (8),
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (accept),
        .en       ((state == PEND) && cpu_busy),
        .at_limit (starve_at_limit)
    );

    assign dma_starved = (state == PEND) && starve_at_limit;
    assign dbg_state   = state;

endmodule

// File: tb/tb_peri_bus_arb.sv
// Directed bench for peri_bus_arb with a completion scoreboard and a bus
// collision monitor; the slave is a fixed ROM returning addr ^ 0xAC.
module tb_peri_bus_arb;

    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] cpu_addr, cpu_dout, cpu_din;
    logic       cpu_wr_en, cpu_rd_en;
    logic [7:0] peri_addr, peri_dout, peri_din;
    logic       peri_wr_en, peri_rd_en;
    logic       dma_req, dma_we;
    logic [7:0] dma_addr, dma_wdata, dma_rdata;
    logic       dma_ready, dma_done, dma_starved;
    logic [1:0] dbg_state;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rd_model = 8'h00;
    bit         coll_en = 1'b0;

    peri_bus_arb #(
        .ADDR_W       (8),
        .DATA_W       (8),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_addr    (cpu_addr),
        .cpu_dout    (cpu_dout),
        .cpu_wr_en   (cpu_wr_en),
        .cpu_rd_en   (cpu_rd_en),
        .cpu_din     (cpu_din),
        .peri_addr   (peri_addr),
        .peri_dout   (peri_dout),
        .peri_wr_en  (peri_wr_en),
        .peri_rd_en  (peri_rd_en),
        .peri_din    (peri_din),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_ready   (dma_ready),
        .dma_done    (dma_done),
        .dma_rdata   (dma_rdata),
        .dma_starved (dma_starved),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset / slave ----------------
    always #5 clk = ~clk;

    assign peri_din = peri_addr ^ 8'hAC;

    // ---------------- driver tasks ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_addr  = 8'h00;
        cpu_dout  = 8'h00;
        cpu_wr_en = 1'b0;
        cpu_rd_en = 1'b0;
        dma_req   = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = 8'h00;
        dma_wdata = 8'h00;
    endtask

    task automatic set_beat(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        dma_req   = 1'b1;
        dma_we    = we;
        dma_addr  = addr;
        dma_wdata = wdata;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Accepted beats push the expected dma_rdata seen at their dma_done.
    always @(negedge clk) begin
        if (reset_n && dma_req && dma_ready) begin
            if (!dma_we) rd_model = dma_addr ^ 8'hAC;
            exp_q.push_back(rd_model);
        end
    end

    always @(negedge clk) begin
        if (reset_n && dma_done) begin
            chk("done_has_beat", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("done_rdata", dma_rdata, exp_q.pop_front());
        end
    end

    // While the CPU strobes, the bus must carry exactly the CPU signals.
    always @(negedge clk) begin
        if (coll_en && reset_n && (cpu_wr_en || cpu_rd_en)) begin
            chk("no_collision", {peri_addr, peri_dout, peri_wr_en, peri_rd_en},
                {cpu_addr, cpu_dout, cpu_wr_en, cpu_rd_en});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        reset_n   = 1'b0;
        cpu_addr  = 8'h33;
        cpu_rd_en = 1'b1;
        repeat (2) @(posedge clk);
        mid();
        chk("rst_ready",   dma_ready,   1);
        chk("rst_done",    dma_done,    0);
        chk("rst_rdata",   dma_rdata,   8'h00);
        chk("rst_starved", dma_starved, 0);
        chk("rst_state",   dbg_state,   2'd0);
        chk("rst_bus",     {peri_addr, peri_rd_en, peri_wr_en}, {8'h33, 1'b1, 1'b0});
        chk("rst_cpu_din", cpu_din,     8'h9F);
        next();
        reset_n = 1'b1;
        idle_inputs();
        next();

        // 1: DMA write with CPU idle
        set_beat(1'b1, 8'h84, 8'hA5);
        mid(); chk("t1_ready_c0", dma_ready, 1);
        next(); dma_req = 1'b0;
        mid();
        chk("t1_bus_c1", {peri_wr_en, peri_rd_en, peri_addr, peri_dout}, {1'b1, 1'b0, 8'h84, 8'hA5});
        chk("t1_ready_c1", dma_ready, 0);
        next();
        mid();
        chk("t1_done_c2", {dma_done, dma_ready, peri_wr_en}, {1'b1, 1'b1, 1'b0});
        next();

        // 2: DMA read deferred by three CPU reads
        set_beat(1'b0, 8'h90, 8'h00);
        mid(); next();
        dma_req   = 1'b0;
        cpu_rd_en = 1'b1;
        cpu_addr  = 8'h80;
        for (int c = 1; c <= 3; c++) begin
            mid();
            chk("t2_cpu_din", cpu_din, 8'h2C);
            chk("t2_cpu_bus", {peri_addr, peri_rd_en}, {8'h80, 1'b1});
            chk("t2_no_done", dma_done, 0);
            next();
        end
        cpu_rd_en = 1'b0;
        mid();
        chk("t2_issue_c4", {peri_rd_en, peri_wr_en, peri_addr, cpu_din}, {1'b1, 1'b0, 8'h90, 8'h00});
        next();
        mid();
        chk("t2_done_c5", {dma_done, dma_rdata}, {1'b1, 8'h3C});
        next();

        // 3: starvation flag with STARVE_LIMIT = 4
        set_beat(1'b1, 8'h10, 8'h55);
        mid(); next();
        dma_req   = 1'b0;
        cpu_wr_en = 1'b1;
        cpu_addr  = 8'h20;
        cpu_dout  = 8'h77;
        for (int c = 1; c <= 6; c++) begin
            mid();
            if (c == 1) chk("t3_cpu_bus", {peri_addr, peri_dout}, {8'h20, 8'h77});
            if (c == 4) chk("t3_not_starved_c4", dma_starved, 0);
            if (c >= 5) chk("t3_starved", dma_starved, 1);
            next();
        end
        cpu_wr_en = 1'b0;
        mid();
        chk("t3_issue_c7", {peri_wr_en, peri_addr, peri_dout}, {1'b1, 8'h10, 8'h55});
        next();
        mid();
        chk("t3_starved_drop", dma_starved, 0);
        chk("t3_done_c8", dma_done, 1);
        next();

        // 4: back-to-back writes with dma_req held
        set_beat(1'b1, 8'h40, 8'h01);
        mid(); next();
        set_beat(1'b1, 8'h41, 8'h02);
        mid(); chk("t4_bus_c1", {peri_wr_en, peri_addr, peri_dout}, {1'b1, 8'h40, 8'h01});
        next();
        mid(); chk("t4_done_c2", {dma_done, peri_wr_en}, {1'b1, 1'b0});
        next();
        set_beat(1'b1, 8'h42, 8'h03);
        mid(); chk("t4_bus_c3", {peri_wr_en, peri_addr, peri_dout}, {1'b1, 8'h41, 8'h02});
        next();
        mid(); chk("t4_done_c4", {dma_done, peri_wr_en}, {1'b1, 1'b0});
        next();
        dma_req = 1'b0;
        mid(); chk("t4_bus_c5", {peri_wr_en, peri_addr, peri_dout, dma_done}, {1'b1, 8'h42, 8'h03, 1'b0});
        next();
        mid(); chk("t4_done_c6", dma_done, 1);
        next();
        mid(); chk("t4_idle_c7", {dma_done, dma_ready}, {1'b0, 1'b1});
        next();

        // 5: reset while a beat is pending
        set_beat(1'b1, 8'h66, 8'h99);
        cpu_rd_en = 1'b1;
        cpu_addr  = 8'h50;
        mid(); next();
        dma_req = 1'b0;
        mid(); chk("t5_pending", dma_ready, 0);
        next();
        reset_n = 1'b0;
        exp_q.delete();
        rd_model = 8'h00;
        mid();
        chk("t5_in_reset", {dma_ready, dma_done, dma_starved, peri_wr_en}, {1'b1, 1'b0, 1'b0, 1'b0});
        next();
        reset_n   = 1'b1;
        cpu_rd_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk("t5_after_reset", {peri_wr_en, dma_done, dma_ready}, {1'b0, 1'b0, 1'b1});
            next();
        end

        // 6: random CPU and DMA traffic
        coll_en = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            int r;
            r         = $urandom_range(0, 4);
            cpu_wr_en = (r == 2) || (r == 4);
            cpu_rd_en = (r == 3) || (r == 4);
            cpu_addr  = 8'($urandom_range(0, 255));
            cpu_dout  = 8'($urandom_range(0, 255));
            dma_req   = 1'($urandom_range(0, 1));
            dma_we    = 1'($urandom_range(0, 1));
            dma_addr  = 8'($urandom_range(0, 255));
            dma_wdata = 8'($urandom_range(0, 255));
            mid();
            next();
        end
        coll_en = 1'b0;
        idle_inputs();
        repeat (4) next();
        mid();
        chk("t6_all_done", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/peri_bus_arb.md
# peri_bus_arb

Cycle-stealing arbiter for the shared 8-bit peripheral bus. It sits between the CPU bus port and the peripheral/RAM fabric, and lets a single DMA-style requester use bus cycles the CPU leaves idle. The CPU has no stall input, so it always wins. DMA beats are queued one at a time and issued in the first cycle where the CPU asserts neither enable.

## Interface
Parameters:
- `ADDR_W`, 8, peripheral address width
- `DATA_W`, 8, data width
- `STARVE_LIMIT`, 255, count of CPU-busy pending cycles at which `dma_starved` asserts; range 1..255

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cpu_addr`  in  ADDR_W  CPU bus address
- `cpu_dout`  in  DATA_W  CPU write data
- `cpu_wr_en`, `cpu_rd_en`  in  1  CPU strobes
- `cpu_din`  out  DATA_W  read data to CPU
- `peri_addr`  out  ADDR_W  shared bus address
- `peri_dout`  out  DATA_W  shared bus write data
- `peri_wr_en`, `peri_rd_en`  out  1  shared bus strobes
- `peri_din`  in  DATA_W  slave read data, valid combinationally in the `peri_rd_en` cycle
- `dma_req`  in  1  beat request
- `dma_we`  in  1  1 = write, 0 = read
- `dma_addr`  in  ADDR_W  beat address
- `dma_wdata`  in  DATA_W  beat write data
- `dma_ready`  out  1  arbiter can accept a beat this cycle
- `dma_done`  out  1  one-cycle pulse when a beat completes
- `dma_rdata`  out  DATA_W  read result; held until the next read completes
- `dma_starved`  out  1  pending beat blocked for `STARVE_LIMIT` CPU-busy cycles

## Operation
**CPU activity.** `cpu_busy = cpu_wr_en | cpu_rd_en`.

**State machine:** IDLE, PEND, DONE.
- **IDLE**
  - `dma_ready` = 1.
  - `dma_req` high: latch `dma_we`, `dma_addr` and `dma_wdata`, then go to PEND.
- **PEND**
  - `dma_ready` = 0.
  - `issue = ~cpu_busy`.
  - On issue: the bus carries the latched beat. If it is a read, capture `peri_din` into `dma_rdata`. Go to DONE.
  - Otherwise stay in PEND.
- **DONE**
  - `dma_done` = 1 and `dma_ready` = 1.
  - `dma_req` high: latch a new beat and go to PEND.
  - Otherwise go to IDLE.

**Bus mux (combinational).**
- When `issue` is high, the bus carries the DMA beat:
  - `peri_addr` = latched address, `peri_dout` = latched data.
  - `peri_wr_en` = latched `we`, `peri_rd_en` = ~latched `we`.
- In every other cycle, the bus carries the CPU signals unchanged.

**CPU read data.** `cpu_din = cpu_rd_en ? peri_din : 0`. The CPU and DMA never share a cycle, so no further gating is needed.

**Starvation counter.**
- 8 bits, clears on entry to PEND.
- Increments each PEND cycle with `cpu_busy` and saturates at `STARVE_LIMIT`.
- `dma_starved` = (count == `STARVE_LIMIT`) while in PEND; 0 in every other state.
- This is advisory only; CPU priority never changes.

**Reset values.**
- State = IDLE, so `dma_ready` = 1.
- `dma_done` = 0, `dma_rdata` = 0, `dma_starved` = 0, counter = 0, latched beat = 0.
- Bus outputs follow the CPU inputs.

**Boundary conditions.**
- **`dma_req` in PEND:** ignored; the requester must hold until `dma_ready`.
- **DMA write completes:** `dma_rdata` is unchanged.
- **Reset asserted in PEND:** the beat is discarded and never reaches the bus; no `dma_done`.
- **Reset asserted in DONE:** the `dma_done` pulse is cut short.
- **Counter at `STARVE_LIMIT`:** holds there; no wrap.
- **CPU and DMA target the same address:** no special handling.

## Timing
- Beat accepted at edge N (`dma_req` & `dma_ready`).
- Earliest bus cycle is N+1. The issue cycle is the first cycle ≥ N+1 with `cpu_busy` = 0.
- `dma_done` and valid `dma_rdata` occur in the cycle after the issue cycle.
- Minimum latency from accept to done is 2 cycles. Maximum sustained throughput is one beat per 2 cycles (DONE → PEND).
- CPU path has zero added latency, purely combinational, so there is no CPU-side wait state.
- Slaves must not rely on a registered `peri_*`; strobes are single-cycle.

## Structure
- Shared package `trsq_bus_pkg` holds:
  - width constants `PERI_ADDR_W` = 8 and `PERI_DATA_W` = 8
  - state enum `arb_state_t` {IDLE, PEND, DONE}
  - `beat_t` struct {we, addr, wdata}
- One sub-module, `starve_cnt`: saturating counter with clear, enable and limit compare. It is reused later for IRQ latency monitoring.

## Test plan
1. **DMA write, CPU idle.** `dma_req` with we=1, addr 0x84, wdata 0xA5 at cycle 0 → cycle 1: `peri_wr_en`=1, `peri_addr`=0x84, `peri_dout`=0xA5; cycle 2: `dma_done`=1.
2. **DMA read deferred by CPU.** DMA read of 0x90 accepted; CPU reads 0x80 in cycles 1–3 → CPU gets slave data in cycles 1–3; DMA issues in cycle 4 with `peri_rd_en`=1 and slave data 0x3C; cycle 5: `dma_done`=1 and `dma_rdata`=0x3C.
3. **Starvation.** `STARVE_LIMIT`=4; beat pending while CPU is busy for 6 cycles → `dma_starved` rises on the 5th PEND cycle and holds; it drops when the beat issues in cycle 7.
4. **Back-to-back beats.** `dma_req` held for 3 writes with the CPU idle → bus writes in cycles 1, 3 and 5; `dma_done` in cycles 2, 4 and 6.
5. **Reset in PEND.** Beat queued with the CPU busy; `reset_n` pulsed low → no `peri_wr_en` from the DMA ever appears, `dma_ready`=1 and `dma_done`=0 after reset.
6. **No collision.** Random CPU and DMA traffic for 10k cycles → the DMA never drives the bus in a `cpu_busy` cycle; every accepted beat gets exactly one `dma_done`.
